br_redirect_ctrl: RTL and testbench

Branch-resolution and fetch-redirect controller for the 5-stage LoongArch pipeline. It sits at the ID/EX boundary and accepts one branch-class instruction at a time: the 8-bit op from the branch decoder, PC, operands and offset. It evaluates the condition, computes the target, drives a valid/ready redirect handshake to IF, flushes wrong-path instructions, and produces the link-register write for BL/JIRL.

---
 rtl/br_redirect_ctrl_pkg.sv | 31 +++
 rtl/br_redirect_ctrl_cond_eval.sv | 38 +++
 rtl/br_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_br_redirect_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_redirect_ctrl_pkg.sv
// Shared definitions for the branch-redirect controller: branch op codes,
// FSM state encodings and a target-alignment helper.
package br_redirect_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_JIRL    = 8'h00,
        OP_B       = 8'h01,
        OP_BL      = 8'h02,
        OP_BEQ     = 8'h03,
        OP_BNE     = 8'h04,
        OP_BLT     = 8'h05,
        OP_BGE     = 8'h06,
        OP_BLTU    = 8'h07,
        OP_BGEU    = 8'h08,
        OP_INVALID = 8'hFF
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDIR  = 2'd1,
        ST_SHADOW = 2'd2
    } br_state_e;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/br_redirect_ctrl_cond_eval.sv
// Combinational branch condition evaluator: op/rj/rd -> taken, is_link, known.
// Unknown ops and OP_INVALID report known=0, taken=0, is_link=0.
module br_cond_eval
    import br_redirect_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] rj,
    input  logic [XLEN-1:0] rd,
    output logic            taken,
    output logic            is_link,
    output logic            known
);

    logic signed [XLEN-1:0] rj_s;
    logic signed [XLEN-1:0] rd_s;

    assign rj_s = rj;
    assign rd_s = rd;

    always_comb begin
        taken   = 1'b0;
        is_link = 1'b0;
        known   = 1'b1;
        case (op)
            OP_JIRL: begin taken = 1'b1; is_link = 1'b1; end
            OP_B:    taken = 1'b1;
            OP_BL:   begin taken = 1'b1; is_link = 1'b1; end
            OP_BEQ:  taken = (rj == rd);
            OP_BNE:  taken = (rj != rd);
            OP_BLT:  taken = (rj_s <  rd_s);
            OP_BGE:  taken = (rj_s >= rd_s);
            OP_BLTU: taken = (rj <  rd);
            OP_BGEU: taken = (rj >= rd);
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Branch resolution and fetch-redirect controller at the ID/EX boundary.
// Optional feature: define BR_STAT_EN to add branch/taken statistic counters.
module br_redirect_ctrl
    import br_redirect_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [OP_W-1:0] id_op,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rj,
    input  logic [XLEN-1:0] id_rd,
    input  logic [XLEN-1:0] id_offs,
    input  logic [4:0]      id_dest,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            flush,
    output logic            link_we,
    output logic [4:0]      link_dest,
    output logic [XLEN-1:0] link_data,
    output logic            br_adef
`ifdef BR_STAT_EN
    ,
    output logic [XLEN-1:0] stat_br_cnt,
    output logic [XLEN-1:0] stat_taken_cnt
`endif
);

    br_state_e       state_p0;
    br_state_e       state_nxt;
    logic            accept;
    logic            taken;
    logic            is_link;
    logic            known;
    logic            misaligned;
    logic            go_redir;
    logic [XLEN-1:0] target;

    logic            redir_valid_p1;
    logic [XLEN-1:0] redir_pc_p1;
    logic            flush_p1;
    logic            link_we_p1;
    logic [4:0]      link_dest_p1;
    logic [XLEN-1:0] link_data_p1;
    logic            br_adef_p1;

    br_cond_eval u_cond (
        .op      (id_op),
        .rj      (id_rj),
        .rd      (id_rd),
        .taken   (taken),
        .is_link (is_link),
        .known   (known)
    );

    assign id_ready   = (state_p0 == ST_IDLE);
    assign accept     = id_valid & id_ready;
    assign target     = ((id_op == OP_JIRL) ? id_rj : id_pc) + id_offs;
    assign misaligned = is_misaligned(target);
    assign go_redir   = accept & known & taken & ~misaligned;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_p0 <= ST_IDLE;
        else         state_p0 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_IDLE:   if (go_redir) state_nxt = ST_REDIR;
            ST_REDIR:  if (redir_ready) state_nxt = ST_SHADOW;
            ST_SHADOW: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: outputs registered from the next-state decode and the accepted instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_valid_p1 <= 1'b0;
            redir_pc_p1    <= '0;
            flush_p1       <= 1'b0;
            link_we_p1     <= 1'b0;
            link_dest_p1   <= '0;
            link_data_p1   <= '0;
            br_adef_p1     <= 1'b0;
        end else begin
            redir_valid_p1 <= (state_nxt == ST_REDIR);
            flush_p1       <= (state_nxt != ST_IDLE);
            link_we_p1     <= accept & is_link;
            br_adef_p1     <= accept & taken & misaligned;
            if (go_redir) redir_pc_p1 <= target;
            if (accept && is_link) begin
                link_dest_p1 <= id_dest;
                link_data_p1 <= id_pc + 32'd4;
            end
        end
    end

    assign redir_valid = redir_valid_p1;
    assign redir_pc    = redir_pc_p1;
    assign flush       = flush_p1;
    assign link_we     = link_we_p1;
    assign link_dest   = link_dest_p1;
    assign link_data   = link_data_p1;
    assign br_adef     = br_adef_p1;

`ifdef BR_STAT_EN
    logic [XLEN-1:0] br_cnt_p1;
    logic [XLEN-1:0] taken_cnt_p1;

    // Taken count includes misaligned targets that only raise br_adef
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt_p1    <= '0;
            taken_cnt_p1 <= '0;
        end else begin
            if (accept && known)          br_cnt_p1    <= br_cnt_p1 + 32'd1;
            if (accept && known && taken) taken_cnt_p1 <= taken_cnt_p1 + 32'd1;
        end
    end

    assign stat_br_cnt    = br_cnt_p1;
    assign stat_taken_cnt = taken_cnt_p1;
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Scoreboard bench for br_redirect_ctrl: directed branches with hand-computed
// link, alignment-fault and redirect expectations checked by a monitor.
module tb_br_redirect_ctrl;
    import br_redirect_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_op;
    logic [31:0] id_pc;
    logic [31:0] id_rj;
    logic [31:0] id_rd;
    logic [31:0] id_offs;
    logic [4:0]  id_dest;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        flush;
    logic        link_we;
    logic [4:0]  link_dest;
    logic [31:0] link_data;
    logic        br_adef;
`ifdef BR_STAT_EN
    logic [31:0] stat_br_cnt;
    logic [31:0] stat_taken_cnt;
`endif

    br_redirect_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_op       (id_op),
        .id_pc       (id_pc),
        .id_rj       (id_rj),
        .id_rd       (id_rd),
        .id_offs     (id_offs),
        .id_dest     (id_dest),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready),
        .flush       (flush),
        .link_we     (link_we),
        .link_dest   (link_dest),
        .link_data   (link_data),
        .br_adef     (br_adef)
`ifdef BR_STAT_EN
        ,
        .stat_br_cnt    (stat_br_cnt),
        .stat_taken_cnt (stat_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam int K_LINK  = 0;
    localparam int K_ADEF  = 1;
    localparam int K_REDIR = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic exp_push(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (sbq.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_unexpected: got event kind %0d a=0x%08h, expected none", kind, a);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_a", a, e.a);
            chk("sb_b", b, e.b);
        end
    endtask

    // Monitor: every output event is matched in order against the scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (link_we) sb_pop(K_LINK, {27'd0, link_dest}, link_data);
            if (br_adef) sb_pop(K_ADEF, 32'd0, 32'd0);
            if (redir_valid && redir_ready) sb_pop(K_REDIR, redir_pc, 32'd0);
        end
    end

    task automatic set_id(input logic [7:0] op, input logic [31:0] pc, input logic [31:0] rj,
                          input logic [31:0] rd, input logic [31:0] offs, input logic [4:0] dest);
        id_valid = 1'b1;
        id_op    = op;
        id_pc    = pc;
        id_rj    = rj;
        id_rd    = rd;
        id_offs  = offs;
        id_dest  = dest;
    endtask

    // Presents one instruction for exactly one edge (caller ensures IDLE)
    task automatic accept_one(input logic [7:0] op, input logic [31:0] pc, input logic [31:0] rj,
                              input logic [31:0] rd, input logic [31:0] offs, input logic [4:0] dest);
        @(posedge clk);
        #1;
        set_id(op, pc, rj, rd, offs, dest);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  k;
        logic got;
        resetn      = 1'b0;
        id_valid    = 1'b0;
        redir_ready = 1'b0;
        set_id(OP_INVALID, 0, 0, 0, 0, 0);
        id_valid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_redir_valid", redir_valid, 0);
        chk("rst_redir_pc", redir_pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_link_we", link_we, 0);
        chk("rst_id_ready", id_ready, 1);
        #1 resetn = 1'b1;

        // BEQ taken with immediate ack
        @(posedge clk); #1 redir_ready = 1'b1;
        exp_push(K_REDIR, 32'h1C000140, 0);
        accept_one(OP_BEQ, 32'h1C000100, 32'd5, 32'd5, 32'h40, 5'd0);
        @(negedge clk);
        chk("beq_redir_valid", redir_valid, 1);
        chk("beq_redir_pc", redir_pc, 32'h1C000140);
        chk("beq_flush_n1", flush, 1);
        chk("beq_ready_n1", id_ready, 0);
        @(negedge clk);
        chk("beq_flush_n2", flush, 1);
        chk("beq_valid_n2", redir_valid, 0);
        chk("beq_ready_n2", id_ready, 0);
        @(negedge clk);
        chk("beq_ready_n3", id_ready, 1);
        chk("beq_flush_n3", flush, 0);

        // BLT signed: -1 < 1 taken
        exp_push(K_REDIR, 32'h00000120, 0);
        accept_one(OP_BLT, 32'h00000100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0);
        @(negedge clk);
        chk("blt_redir_valid", redir_valid, 1);
        @(negedge clk);
        @(negedge clk);
        chk("blt_ready_back", id_ready, 1);

        // BLTU unsigned: 0xFFFFFFFF < 1 not taken
        accept_one(OP_BLTU, 32'h00000100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0);
        @(negedge clk);
        chk("bltu_redir_valid", redir_valid, 0);
        chk("bltu_flush", flush, 0);
        chk("bltu_ready", id_ready, 1);

        // Back-to-back not-taken accepts, including an unknown op
        @(posedge clk); #1 set_id(OP_BNE, 32'h200, 32'd7, 32'd7, 32'h10, 5'd0);
        @(negedge clk); chk("b2b_ready_0", id_ready, 1);
        @(posedge clk); #1 set_id(OP_BGEU, 32'h204, 32'd1, 32'hFFFFFFFF, 32'h10, 5'd0);
        @(negedge clk); chk("b2b_ready_1", id_ready, 1);
        @(posedge clk); #1 set_id(8'h55, 32'h208, 32'd1, 32'd1, 32'h10, 5'd9);
        @(negedge clk); chk("b2b_ready_2", id_ready, 1);
        @(posedge clk); #1 id_valid = 1'b0;
        @(negedge clk);
        chk("b2b_redir_valid", redir_valid, 0);
        chk("b2b_link_we", link_we, 0);
        chk("b2b_id_ready", id_ready, 1);

        // JIRL aligned: register-relative target plus link
        exp_push(K_LINK, 32'd3, 32'h1C000204);
        exp_push(K_REDIR, 32'h1C001008, 0);
        accept_one(OP_JIRL, 32'h1C000200, 32'h1C001000, 32'd0, 32'h8, 5'd3);
        @(negedge clk);
        chk("jirl_link_we", link_we, 1);
        chk("jirl_redir_valid", redir_valid, 1);
        @(negedge clk);
        chk("jirl_link_pulse", link_we, 0);
        @(negedge clk);

        // JIRL misaligned: address fault, link still written, no redirect
        exp_push(K_LINK, 32'd5, 32'h1C000304);
        exp_push(K_ADEF, 0, 0);
        accept_one(OP_JIRL, 32'h1C000300, 32'h1C001002, 32'd0, 32'h0, 5'd5);
        @(negedge clk);
        chk("adef_pulse", br_adef, 1);
        chk("adef_redir_valid", redir_valid, 0);
        chk("adef_flush", flush, 0);
        chk("adef_ready", id_ready, 1);
        @(negedge clk);
        chk("adef_pulse_end", br_adef, 0);

        // BL with IF stalling, second branch waits behind it
        @(posedge clk); #1 redir_ready = 1'b0;
        exp_push(K_LINK, 32'd1, 32'h1C000404);
        exp_push(K_REDIR, 32'h1C000300, 0);
        exp_push(K_REDIR, 32'h00002010, 0);
        accept_one(OP_BL, 32'h1C000400, 32'd0, 32'd0, 32'hFFFFFF00, 5'd1);
        set_id(OP_B, 32'h00002000, 32'd0, 32'd0, 32'h10, 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_redir_valid", redir_valid, 1);
            chk("stall_redir_pc", redir_pc, 32'h1C000300);
            chk("stall_id_ready", id_ready, 0);
        end
        @(posedge clk); #1 redir_ready = 1'b1;
        got = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (id_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("stall_release", got, 1);
        @(posedge clk); #1 id_valid = 1'b0;
        @(negedge clk);
        chk("second_redir_valid", redir_valid, 1);
        chk("second_redir_pc", redir_pc, 32'h00002010);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset while a redirect is pending
        @(posedge clk); #1 redir_ready = 1'b0;
        accept_one(OP_B, 32'h00003000, 32'd0, 32'd0, 32'h40, 5'd0);
        @(negedge clk);
        chk("pre_rst_redir_valid", redir_valid, 1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_redir_valid", redir_valid, 0);
        chk("arst_redir_pc", redir_pc, 0);
        chk("arst_flush", flush, 0);
        chk("arst_link_data", link_data, 0);
        chk("arst_link_dest", {27'd0, link_dest}, 0);
        chk("arst_br_adef", br_adef, 0);
        @(negedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", id_ready, 1);
        chk("post_rst_redir_valid", redir_valid, 0);
`ifdef BR_STAT_EN
        chk("rst_stat_br", stat_br_cnt, 0);
        chk("rst_stat_taken", stat_taken_cnt, 0);
`endif

        // Not-taken BEQ counts as a branch; OP_INVALID does not
        accept_one(OP_BEQ, 32'h400, 32'd1, 32'd2, 32'h10, 5'd0);
        accept_one(OP_INVALID, 32'h404, 32'd0, 32'd0, 32'h10, 5'd0);
        @(negedge clk);
        chk("inv_redir_valid", redir_valid, 0);
        chk("inv_ready", id_ready, 1);
`ifdef BR_STAT_EN
        chk("stat_br", stat_br_cnt, 1);
        chk("stat_taken", stat_taken_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
